puf_race_sequencer: RTL and testbench
=====================================

Name: puf_race_sequencer

Overview:
- Sequences a ring-oscillator race PUF across NUM_CHAL challenges and packs the response bits into bytes.
- For each challenge it drives the mux select, clears the two post-mux edge counters, lets the oscillators settle, then enables both counters.
- The response bit is set by which counter raises its finished flag first.
- Sits between the post-mux counters and the serial output path. Bytes leave over a valid/ready handshake.

Parameters:
- NUM_CHAL, 64: number of challenges per run. Must be a multiple of 8 and ≤ 2^CHAL_W.
- CHAL_W, 7: width of the challenge select.
- SETTLE_CYC, 4: clocks of settling after a counter clear, before counting starts. Must be ≥ 1.
- WIN_CYC, 1024: timeout, in clocks of MEASURE, before a race is abandoned.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a run; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until DONE is exited
- done  out  1  one-cycle pulse in the DONE state
- chal_sel  out  CHAL_W  current challenge index, sent to the oscillator muxes
- cnt_clr  out  1  clear to both post-mux counters
- cnt_en  out  1  enable to both post-mux counters
- fin_a  in  1  finished flag, counter A
- fin_b  in  1  finished flag, counter B
- resp_data  out  8  response byte
- resp_valid  out  1  resp_data is valid
- resp_ready  in  1  downstream accepts the byte
- tie_seen  out  1  sticky: at least one race ended in a tie
- timeout_seen  out  1  sticky: at least one race timed out

Behaviour:
- Reset values: state=IDLE, chal_sel=0, cnt_clr=1, cnt_en=0, busy=0, done=0, resp_data=0, resp_valid=0, sticky flags=0, all internal counters=0.
- Reset asserted mid-run aborts the run immediately. No partial byte is emitted.
- All outputs are registered.
- IDLE:
  - cnt_clr=1, cnt_en=0.
  - On start: chal_idx=0, bit_idx=0, tie_seen=0, timeout_seen=0, busy=1, go to CLEAR.
- CLEAR (1 cycle):
  - cnt_clr=1, chal_sel=chal_idx.
  - Go to SETTLE with settle timer = SETTLE_CYC-1.
- SETTLE:
  - cnt_clr=0, cnt_en=0.
  - Timer decrements each clock. At 0 go to MEASURE with window timer = 0.
- MEASURE:
  - cnt_en=1. fin_a and fin_b are sampled every cycle.
  - fin_a=1, fin_b=0: bit=1.
  - fin_a=0, fin_b=1: bit=0.
  - Both 1 in the same cycle: bit=0, tie_seen set.
  - Window timer reaches WIN_CYC-1 with neither flag set: bit=0, timeout_seen set.
  - Any of these cases goes to STORE, and cnt_en drops on the same edge.
- STORE (1 cycle):
  - Write resp_data[bit_idx]=bit. Bit i of a byte is the race result of challenge 8k+i.
  - If bit_idx=7, go to EMIT. Otherwise bit_idx++, chal_idx++, go to CLEAR.
- EMIT:
  - resp_valid=1. resp_data is held stable until the transfer.
  - Transfer occurs on a clock edge where resp_valid=1 and resp_ready=1.
  - After transfer: resp_valid=0, bit_idx=0.
  - If chal_idx=NUM_CHAL-1, go to DONE. Otherwise chal_idx++, go to CLEAR.
  - No new race starts while a byte is pending (backpressure stalls the run).
- DONE (1 cycle): done=1, busy=0 on exit, cnt_clr=1, go to IDLE.
- Timing per challenge, excluding EMIT stall: 1 (CLEAR) + SETTLE_CYC + race cycles + 1 (STORE).
- chal_idx never wraps within a run. start in any non-IDLE state is ignored.
- resp_data is cleared to 0 on entry to CLEAR when bit_idx=0.

Decomposition:
- Shared package puf_pkg holds:
  - the state enum (IDLE, CLEAR, SETTLE, MEASURE, STORE, EMIT, DONE);
  - the RESP_BYTE_W=8 constant;
  - the default NUM_CHAL, SETTLE_CYC and WIN_CYC constants.
- One natural sub-module: puf_resp_packer, an 8-bit bit-indexed packer with the valid/ready output register.

Test Plan:
- NUM_CHAL=8, resp_ready=1. fin_a rises 10 cycles before fin_b on odd challenges, fin_b first on even challenges -> one byte 8'hAA, then done pulses exactly once and busy falls.
- fin_a and fin_b rise in the same cycle for challenge 3 -> bit 3 = 0, tie_seen=1, timeout_seen=0.
- WIN_CYC=16, no flags for challenge 0 -> MEASURE lasts exactly 16 cycles, bit=0, timeout_seen=1, sequence continues to challenge 1.
- resp_ready held low for 20 cycles after byte 0 -> resp_valid stays 1, resp_data stable, no cnt_clr pulse until the transfer; byte 1 then completes normally.
- Reset asserted during MEASURE of challenge 5 -> all outputs at reset values next cycle; a new start produces chal_sel=0 in the first CLEAR.
- start pulsed while busy=1 -> ignored; NUM_CHAL=16 run emits exactly 2 bytes and 1 done pulse.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and defaults for the ring-oscillator race PUF sequencer.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_MEASURE,
    ST_STORE,
    ST_EMIT,
    ST_DONE
  } puf_state_e;

  localparam int RESP_BYTE_W    = 8;
  localparam int DEF_NUM_CHAL   = 64;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_WIN_CYC    = 1024;

endpackage

// File: rtl/puf_resp_packer.sv
// Bit-indexed response byte builder with a valid/ready output register.
module puf_resp_packer
  import puf_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr_i,
  input  logic                           wr_en_i,
  input  logic [$clog2(RESP_BYTE_W)-1:0] wr_idx_i,
  input  logic                           wr_bit_i,
  input  logic                           load_i,
  input  logic                           ready_i,
  output logic [RESP_BYTE_W-1:0]         data_o,
  output logic                           valid_o
);

  logic [RESP_BYTE_W-1:0] data_q;
  logic                   valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (clr_i) begin
        data_q <= '0;
      end else if (wr_en_i) begin
        data_q[wr_idx_i] <= wr_bit_i;
      end
      if (load_i) begin
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/puf_race_sequencer.sv
// Steps the PUF mux through every challenge, races the two counters and packs results.
// state   | meaning
// IDLE    | counters held clear, wait for start
// CLEAR   | drive chal_sel, clear counters (1 cycle)
// SETTLE  | counters idle while oscillators settle
// MEASURE | counters enabled, wait for first finish flag or window end
// STORE   | write race bit into the packer (1 cycle)
// EMIT    | byte offered downstream, run stalls until taken
// DONE    | one-cycle completion pulse
module puf_race_sequencer
  import puf_pkg::*;
#(
  parameter int NUM_CHAL   = DEF_NUM_CHAL,
  parameter int CHAL_W     = 7,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int WIN_CYC    = DEF_WIN_CYC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [CHAL_W-1:0]      chal_sel,
  output logic                   cnt_clr,
  output logic                   cnt_en,
  input  logic                   fin_a,
  input  logic                   fin_b,
  output logic [RESP_BYTE_W-1:0] resp_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   tie_seen,
  output logic                   timeout_seen
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int WIN_W = $clog2(WIN_CYC + 1);
  localparam int BIT_W = $clog2(RESP_BYTE_W);

  puf_state_e        state_q, state_d;
  logic [CHAL_W-1:0] chal_idx_q, chal_idx_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              bit_q, bit_d;
  logic              tie_q, tie_d;
  logic              to_q, to_d;
  logic              cnt_clr_q, cnt_en_q, busy_q, done_q;
  logic [CHAL_W-1:0] chal_sel_q;
  logic              xfer;

  assign xfer = resp_valid && resp_ready;

  always_comb begin
    state_d    = state_q;
    chal_idx_d = chal_idx_q;
    bit_idx_d  = bit_idx_q;
    settle_d   = settle_q;
    win_d      = win_q;
    bit_d      = bit_q;
    tie_d      = tie_q;
    to_d       = to_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          chal_idx_d = '0;
          bit_idx_d  = '0;
          tie_d      = 1'b0;
          to_d       = 1'b0;
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        settle_d = SET_W'(SETTLE_CYC - 1);
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          win_d   = '0;
          state_d = ST_MEASURE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_MEASURE: begin
        if (fin_a && fin_b) begin
          bit_d   = 1'b0;
          tie_d   = 1'b1;
          state_d = ST_STORE;
        end else if (fin_a) begin
          bit_d   = 1'b1;
          state_d = ST_STORE;
        end else if (fin_b) begin
          bit_d   = 1'b0;
          state_d = ST_STORE;
        end else if (win_q == WIN_W'(WIN_CYC - 1)) begin
          bit_d   = 1'b0;
          to_d    = 1'b1;
          state_d = ST_STORE;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      ST_STORE: begin
        if (bit_idx_q == BIT_W'(RESP_BYTE_W - 1)) begin
          state_d = ST_EMIT;
        end else begin
          bit_idx_d  = bit_idx_q + 1'b1;
          chal_idx_d = chal_idx_q + 1'b1;
          state_d    = ST_CLEAR;
        end
      end
      ST_EMIT: begin
        if (xfer) begin
          bit_idx_d = '0;
          if (chal_idx_q == CHAL_W'(NUM_CHAL - 1)) begin
            state_d = ST_DONE;
          end else begin
            chal_idx_d = chal_idx_q + 1'b1;
            state_d    = ST_CLEAR;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      chal_idx_q <= '0;
      bit_idx_q  <= '0;
      settle_q   <= '0;
      win_q      <= '0;
      bit_q      <= 1'b0;
      tie_q      <= 1'b0;
      to_q       <= 1'b0;
      cnt_clr_q  <= 1'b1;
      cnt_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      chal_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      chal_idx_q <= chal_idx_d;
      bit_idx_q  <= bit_idx_d;
      settle_q   <= settle_d;
      win_q      <= win_d;
      bit_q      <= bit_d;
      tie_q      <= tie_d;
      to_q       <= to_d;
      cnt_clr_q  <= (state_d == ST_IDLE) || (state_d == ST_CLEAR) || (state_d == ST_DONE);
      cnt_en_q   <= (state_d == ST_MEASURE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      if (state_d == ST_CLEAR) begin
        chal_sel_q <= chal_idx_d;
      end
    end
  end

  puf_resp_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    ((state_d == ST_CLEAR) && (bit_idx_d == '0)),
    .wr_en_i  (state_q == ST_STORE),
    .wr_idx_i (bit_idx_q),
    .wr_bit_i (bit_q),
    .load_i   ((state_q == ST_STORE) && (bit_idx_q == BIT_W'(RESP_BYTE_W - 1))),
    .ready_i  (resp_ready),
    .data_o   (resp_data),
    .valid_o  (resp_valid)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign chal_sel     = chal_sel_q;
  assign cnt_clr      = cnt_clr_q;
  assign cnt_en       = cnt_en_q;
  assign tie_seen     = tie_q;
  assign timeout_seen = to_q;

endmodule

// File: tb/tb_puf_race_sequencer.sv
// Directed bench: a simple edge-counter model races per-challenge finish times.
module tb_puf_race_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, cnt_clr, cnt_en;
  logic [6:0] chal_sel;
  logic       fin_a, fin_b;
  logic [7:0] resp_data;
  logic       resp_valid, resp_ready;
  logic       tie_seen, timeout_seen;

  int n_checks = 0;
  int n_errors = 0;

  int ta_tab [16];
  int tb_tab [16];
  int cnt;
  int done_cnt = 0;
  int m0_cnt   = 0;
  logic [7:0] bytes_q [$];

  logic [21:0] outs;
  localparam logic [21:0] RST_OUTS = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 8'd0};

  always #5 clk = ~clk;

  puf_race_sequencer #(
    .NUM_CHAL   (16),
    .CHAL_W     (7),
    .SETTLE_CYC (4),
    .WIN_CYC    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .chal_sel     (chal_sel),
    .cnt_clr      (cnt_clr),
    .cnt_en       (cnt_en),
    .fin_a        (fin_a),
    .fin_b        (fin_b),
    .resp_data    (resp_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .tie_seen     (tie_seen),
    .timeout_seen (timeout_seen)
  );

  assign outs  = {busy, done, cnt_clr, cnt_en, resp_valid, tie_seen, timeout_seen, chal_sel, resp_data};
  assign fin_a = (ta_tab[chal_sel[3:0]] != 0) && (cnt >= ta_tab[chal_sel[3:0]]);
  assign fin_b = (tb_tab[chal_sel[3:0]] != 0) && (cnt >= tb_tab[chal_sel[3:0]]);

  // Post-mux edge counter model: a flag rises once the count reaches its finish time.
  always @(posedge clk or posedge reset) begin
    if (reset)        cnt <= 0;
    else if (cnt_clr) cnt <= 0;
    else if (cnt_en)  cnt <= cnt + 1;
  end

  always @(posedge clk) begin
    if (resp_valid && resp_ready) bytes_q.push_back(resp_data);
    if (done) done_cnt <= done_cnt + 1;
    if (cnt_en && chal_sel == 7'd0) m0_cnt <= m0_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind 0: odd challenges A first; 1: same with a tie on challenge 3;
  // 2: A always first except challenge 0, where neither counter finishes.
  task automatic set_pattern(input int kind);
    for (int i = 0; i < 16; i++) begin
      if (kind == 2 || (i % 2) == 1) begin
        ta_tab[i] = 2;  tb_tab[i] = 12;
      end else begin
        ta_tab[i] = 12; tb_tab[i] = 2;
      end
    end
    if (kind == 1) begin
      ta_tab[3] = 5; tb_tab[3] = 5;
    end
    if (kind == 2) begin
      ta_tab[0] = 0; tb_tab[0] = 0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit extra);
    bit idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(negedge clk);
      start = extra && (i == 40 || i == 150);
      if (!busy) idle = 1'b1;
    end
    start = 1'b0;
    check({tag, "_finished"}, 32'(idle), 32'd1);
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [7:0] e0, input logic [7:0] e1);
    check({tag, "_nbytes"}, 32'(bytes_q.size() - base), 32'd2);
    if (bytes_q.size() >= base + 2) begin
      check({tag, "_byte0"}, 32'(bytes_q[base]), 32'(e0));
      check({tag, "_byte1"}, 32'(bytes_q[base + 1]), 32'(e1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, d, m;
    bit found, okv, oks, act;
    logic [7:0] data0;

    reset = 1'b1; start = 1'b0; resp_ready = 1'b1;
    set_pattern(0);
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs), 32'(RST_OUTS));
    reset = 1'b0;

    // Alternating winners: one byte AA per 8 challenges.
    b = bytes_q.size(); d = done_cnt;
    pulse_start();
    check("t1_busy_after_start", 32'(busy), 32'd1);
    wait_idle("t1", 1'b0);
    check_bytes("t1", b, 8'hAA, 8'hAA);
    check("t1_done_once", 32'(done_cnt - d), 32'd1);
    check("t1_flags", 32'({tie_seen, timeout_seen}), 32'd0);

    // Tie on challenge 3.
    set_pattern(1);
    b = bytes_q.size();
    pulse_start();
    wait_idle("t2", 1'b0);
    check_bytes("t2", b, 8'hA2, 8'hAA);
    check("t2_flags", 32'({tie_seen, timeout_seen}), 32'b10);

    // Timeout on challenge 0: full 16-cycle window, then run continues.
    set_pattern(2);
    b = bytes_q.size(); m = m0_cnt;
    pulse_start();
    wait_idle("t3", 1'b0);
    check("t3_measure_len", 32'(m0_cnt - m), 32'd16);
    check_bytes("t3", b, 8'hFE, 8'hFF);
    check("t3_flags", 32'({tie_seen, timeout_seen}), 32'b01);

    // Backpressure after byte 0.
    set_pattern(0);
    resp_ready = 1'b0;
    b = bytes_q.size(); d = done_cnt;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (resp_valid) found = 1'b1;
    end
    check("t4_valid_seen", 32'(found), 32'd1);
    data0 = resp_data; okv = 1'b1; oks = 1'b1; act = 1'b0;
    repeat (20) begin
      @(negedge clk);
      okv = okv & resp_valid;
      oks = oks & (resp_data == data0);
      act = act | cnt_clr | cnt_en;
    end
    check("t4_valid_held", 32'(okv), 32'd1);
    check("t4_data_stable", 32'(oks), 32'd1);
    check("t4_no_race_while_stalled", 32'(act), 32'd0);
    check("t4_stalled_byte", 32'(data0), 32'hAA);
    resp_ready = 1'b1;
    wait_idle("t4", 1'b0);
    check_bytes("t4", b, 8'hAA, 8'hAA);
    check("t4_done_once", 32'(done_cnt - d), 32'd1);
    check("t4_flags", 32'({tie_seen, timeout_seen}), 32'd0);

    // Reset during MEASURE of challenge 5.
    b = bytes_q.size();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (cnt_en && chal_sel == 7'd5) found = 1'b1;
    end
    check("t5_reached_chal5", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_reset_outs", 32'(outs), 32'(RST_OUTS));
    @(negedge clk);
    check("t5_reset_outs_hold", 32'(outs), 32'(RST_OUTS));
    reset = 1'b0;
    check("t5_no_partial_byte", 32'(bytes_q.size() - b), 32'd0);
    b = bytes_q.size();
    pulse_start();
    check("t5_first_clear", 32'({busy, cnt_clr, cnt_en, chal_sel}), 32'({1'b1, 1'b1, 1'b0, 7'd0}));
    wait_idle("t5", 1'b0);
    check_bytes("t5", b, 8'hAA, 8'hAA);

    // start pulses while busy must be ignored.
    b = bytes_q.size(); d = done_cnt;
    pulse_start();
    wait_idle("t6", 1'b1);
    repeat (30) @(negedge clk);
    check("t6_stays_idle", 32'(busy), 32'd0);
    check_bytes("t6", b, 8'hAA, 8'hAA);
    check("t6_done_once", 32'(done_cnt - d), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
